// File: rtl/maze_walker.sv
// Grid walker: debounced direction buttons step a player through a bitmap maze,
// with wall and edge checking, a goal state, and one-cycle move/bump pulses.

module maze_walker_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic lvl_o
);
  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          lvl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      // The level flips on the last of DEBOUNCE_CYCLES consecutive mismatching cycles.
      if (sync_q[1] != lvl_q) begin
        if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          lvl_q <= sync_q[1];
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign lvl_o = lvl_q;
endmodule

module maze_walker #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int MAZE_MAX        = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         restart,
  input  logic [3:0]                   btn,
  input  logic [MAZE_MAX*MAZE_MAX-1:0] maze_data,
  input  logic [6:0]                   maze_width,
  input  logic [6:0]                   maze_height,
  output logic [6:0]                   x_coord,
  output logic [6:0]                   y_coord,
  output logic                         move_pulse,
  output logic                         bump,
  output logic                         at_goal
);
  localparam int NUM_BTN = 4;
  localparam int AW      = $clog2(MAZE_MAX * MAZE_MAX);

  typedef enum logic [1:0] {IDLE, CHECK, MOVE, GOAL} state_t;
  typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

  logic [NUM_BTN-1:0] lvl, lvl_prev_q, rise;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    maze_walker_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst_n (reset),
      .btn_i (btn[i]),
      .lvl_o (lvl[i])
    );
  end

  assign rise = lvl & ~lvl_prev_q;

  state_t     state_q;
  dir_t       dir_q, dir_d;
  logic [6:0] x_q, y_q, x_d, y_d;
  logic [6:0] w_eff, h_eff;
  logic       move_q, bump_q, goal_q;
  logic       oob, cell_open, at_corner;
  logic [AW-1:0] idx;

  assign w_eff = (maze_width  > 7'(MAZE_MAX)) ? 7'(MAZE_MAX) : maze_width;
  assign h_eff = (maze_height > 7'(MAZE_MAX)) ? 7'(MAZE_MAX) : maze_height;

  always_comb begin
    if (rise[0])      dir_d = D_UP;
    else if (rise[1]) dir_d = D_DOWN;
    else if (rise[2]) dir_d = D_LEFT;
    else              dir_d = D_RIGHT;
  end

  // Target cell and legality; only consumed while in CHECK.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    oob = 1'b0;
    case (dir_q)
      D_UP:    if (y_q == 7'd0) oob = 1'b1; else y_d = y_q - 7'd1;
      D_DOWN:  if (h_eff < 7'd2 || y_q >= h_eff - 7'd1) oob = 1'b1; else y_d = y_q + 7'd1;
      D_LEFT:  if (x_q == 7'd0) oob = 1'b1; else x_d = x_q - 7'd1;
      default: if (w_eff < 7'd2 || x_q >= w_eff - 7'd1) oob = 1'b1; else x_d = x_q + 7'd1;
    endcase
    idx       = AW'(int'(y_d) * MAZE_MAX + int'(x_d));
    cell_open = maze_data[idx];
  end

  assign at_corner = (x_q == w_eff - 7'd1) && (y_q == h_eff - 7'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      dir_q      <= D_UP;
      x_q        <= '0;
      y_q        <= '0;
      move_q     <= 1'b0;
      bump_q     <= 1'b0;
      goal_q     <= 1'b0;
      lvl_prev_q <= '0;
    end else begin
      lvl_prev_q <= lvl;
      move_q     <= 1'b0;
      bump_q     <= 1'b0;
      if (restart) begin
        x_q     <= '0;
        y_q     <= '0;
        goal_q  <= 1'b0;
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (enable && |rise) begin
            dir_q   <= dir_d;
            state_q <= CHECK;
          end
          CHECK: if (oob || !cell_open) begin
            bump_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            // Coordinates and pulse land together with entry into MOVE.
            x_q     <= x_d;
            y_q     <= y_d;
            move_q  <= 1'b1;
            state_q <= MOVE;
          end
          MOVE: if (at_corner) begin
            goal_q  <= 1'b1;
            state_q <= GOAL;
          end else begin
            state_q <= IDLE;
          end
          default: state_q <= GOAL;
        endcase
      end
    end
  end

  assign x_coord    = x_q;
  assign y_coord    = y_q;
  assign move_pulse = move_q;
  assign bump       = bump_q;
  assign at_goal    = goal_q;
endmodule

// File: tb/tb_maze_walker.sv
// Directed bench for maze_walker with DEBOUNCE_CYCLES=4.

module tb_maze_walker;
  logic        clk, reset, enable, restart;
  logic [3:0]  btn;
  logic [4095:0] maze;
  logic [6:0]  mw, mh, x, y;
  logic        mp, bp, ag;
  int total = 0, passes = 0, fails = 0;
  int nmv, nbp;

  maze_walker #(.DEBOUNCE_CYCLES(4), .MAZE_MAX(64)) dut (
    .clk(clk), .reset(reset), .enable(enable), .restart(restart), .btn(btn),
    .maze_data(maze), .maze_width(mw), .maze_height(mh),
    .x_coord(x), .y_coord(y), .move_pulse(mp), .bump(bp), .at_goal(ag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Hold buttons, release, let the release debounce; count pulse-high cycles.
  task automatic press(input logic [3:0] b, input int hold, output int mv, output int bu);
    mv = 0; bu = 0;
    btn = b;
    repeat (hold) begin @(negedge clk); mv += int'(mp); bu += int'(bp); end
    btn = 4'b0;
    repeat (16) begin @(negedge clk); mv += int'(mp); bu += int'(bp); end
  endtask

  task automatic do_restart();
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; restart = 1'b0; btn = 4'b0;
    maze = '0;
    for (int i = 0; i < 8; i++) maze[i] = 1'b1;
    maze[65] = 1'b1; maze[66] = 1'b1;
    mw = 7'd8; mh = 7'd8;
    #1 reset = 1'b0;
    #2;
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_mp", mp, 0);
    check("rst_bump", bp, 0);
    check("rst_goal", ag, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    press(4'b0100, 10, nmv, nbp);
    check("left_edge_bump", nbp, 1);
    check("left_edge_mv", nmv, 0);
    check("left_edge_x", x, 0);
    press(4'b0010, 10, nmv, nbp);
    check("down_wall_bump", nbp, 1);
    check("down_wall_mv", nmv, 0);
    check("down_wall_y", y, 0);

    // Debounced level rises at posedge 6, CHECK at 7, move visible after 8.
    @(negedge clk); btn = 4'b1000;
    repeat (7) @(negedge clk);
    check("lat_check_mp", mp, 0);
    check("lat_check_x", x, 0);
    @(negedge clk);
    check("lat_move_mp", mp, 1);
    check("lat_move_x", x, 1);
    nmv = 0; nbp = 0;
    repeat (2) begin @(negedge clk); nmv += int'(mp); nbp += int'(bp); end
    btn = 4'b0;
    repeat (16) begin @(negedge clk); nmv += int'(mp); nbp += int'(bp); end
    check("right_no_repeat", nmv, 0);
    check("right_no_bump", nbp, 0);
    check("right_y", y, 0);

    enable = 1'b0;
    press(4'b1000, 10, nmv, nbp);
    check("disabled_mv", nmv, 0);
    check("disabled_x", x, 1);
    enable = 1'b1;

    press(4'b1000, 3, nmv, nbp);
    check("glitch_mv", nmv, 0);
    check("glitch_bump", nbp, 0);
    check("glitch_x", x, 1);

    press(4'b0010, 10, nmv, nbp);
    check("down_open_mv", nmv, 1);
    check("down_open_y", y, 1);

    press(4'b1001, 10, nmv, nbp);
    check("prio_mv", nmv, 1);
    check("prio_bump", nbp, 0);
    check("prio_x", x, 1);
    check("prio_y", y, 0);

    do_restart();
    check("restart_x", x, 0);
    check("restart_y", y, 0);

    mw = 7'd2; mh = 7'd2;
    press(4'b1000, 10, nmv, nbp);
    check("g_right_x", x, 1);
    check("g_right_goal", ag, 0);
    press(4'b0010, 10, nmv, nbp);
    check("g_down_mv", nmv, 1);
    check("g_down_y", y, 1);
    check("g_goal", ag, 1);
    press(4'b0100, 10, nmv, nbp);
    check("g_ignore_mv", nmv, 0);
    check("g_ignore_bump", nbp, 0);
    check("g_ignore_x", x, 1);
    check("g_hold_goal", ag, 1);
    do_restart();
    check("g_restart_x", x, 0);
    check("g_restart_y", y, 0);
    check("g_restart_goal", ag, 0);

    press(4'b1000, 10, nmv, nbp);
    check("pre_abort_x", x, 1);
    @(negedge clk); btn = 4'b0010;
    repeat (7) @(negedge clk);
    reset = 1'b0; btn = 4'b0;
    #1;
    check("abort_x", x, 0);
    check("abort_y", y, 0);
    check("abort_mp", mp, 0);
    check("abort_bump", bp, 0);
    check("abort_goal", ag, 0);
    @(negedge clk); reset = 1'b1;
    nmv = 0; nbp = 0;
    repeat (20) begin @(negedge clk); nmv += int'(mp); nbp += int'(bp); end
    check("post_abort_mv", nmv, 0);
    check("post_abort_bump", nbp, 0);
    press(4'b1000, 10, nmv, nbp);
    check("resume_mv", nmv, 1);
    check("resume_x", x, 1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/maze_walker.md
MAZE_WALKER -- requirements
Module: maze_walker

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning the number of consecutive stable clk cycles before a button level is accepted (1 ms at 50 MHz).
REQ-002 SHALL have parameter MAZE_MAX, default 64, meaning the maze side length in cells and the row stride of maze_data.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1 bit: 1 allows moves to be accepted.
REQ-006 SHALL have port restart, input, 1 bit: synchronous return of the player to cell (0,0).
REQ-007 SHALL have port btn, input, 4 bits: raw, asynchronous direction buttons; [0]=up, [1]=down, [2]=left, [3]=right.
REQ-008 SHALL have port maze_data, input, 4096 bits: cell (x,y) open if bit y*64+x is 1, wall if 0.
REQ-009 SHALL have port maze_width, input, 7 bits: active maze width in cells.
REQ-010 SHALL have port maze_height, input, 7 bits: active maze height in cells.
REQ-011 SHALL have port x_coord, output, 7 bits: player column.
REQ-012 SHALL have port y_coord, output, 7 bits: player row.
REQ-013 SHALL have port move_pulse, output, 1 bit: one-cycle pulse on each accepted move.
REQ-014 SHALL have port bump, output, 1 bit: one-cycle pulse on each rejected move.
REQ-015 SHALL have port at_goal, output, 1 bit: level, 1 while in state GOAL.

Function
REQ-016 SHALL pass each btn bit through a 2-flop synchronizer, then a per-button counter; the debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles, and any mismatch-free cycle clears the counter.
REQ-017 SHALL raise one request per 0->1 edge of a debounced level; holding a button produces no repeat requests.
REQ-018 SHALL, on simultaneous requests, accept only one, with priority up>down>left>right, and discard the rest.
REQ-019 SHALL clamp effective width and height to MAZE_MAX when the inputs exceed it.
REQ-020 SHALL implement FSM states IDLE, CHECK, MOVE, GOAL.
REQ-021 IDLE: on a request with enable=1, SHALL latch the direction and go to CHECK; requests with enable=0 are dropped.
REQ-022 CHECK: SHALL compute the target cell (up=y-1, down=y+1, left=x-1, right=x+1).
REQ-023 CHECK: if the target is out of bounds (x=0 left, y=0 up, x=width-1 right, y=height-1 down, or width/height <2 on that axis), SHALL pulse bump and return to IDLE.
REQ-024 CHECK: if the target cell's maze_data bit is 0, SHALL pulse bump and return to IDLE.
REQ-025 CHECK: otherwise SHALL go to MOVE.
REQ-026 MOVE: SHALL update x_coord/y_coord to the target and pulse move_pulse in the same cycle, then go to GOAL if the target is (width-1, height-1), else to IDLE.
REQ-027 Latency: a debounced rising edge registered at cycle T SHALL yield CHECK at T+1 and updated coordinates plus move_pulse (or bump) visible at T+2.
REQ-028 GOAL: SHALL hold at_goal=1 and ignore all requests.
REQ-029 restart=1 SHALL, in any state, set coordinates to (0,0), enter IDLE and clear at_goal on the next edge, taking priority over a simultaneous MOVE.
REQ-030 SHALL sample maze_data only in CHECK; changes to it in other states have no effect.

Reset
REQ-031 reset=0 SHALL immediately set x_coord=0, y_coord=0, move_pulse=0, bump=0, at_goal=0, FSM=IDLE, all debounced levels=0, and all counters=0, independent of clk.
REQ-032 reset asserted mid-move (CHECK or MOVE) SHALL abort the move with no pulse emitted; after release the next edge resumes from IDLE.

Verification
REQ-033 DEBOUNCE_CYCLES=4, open row 0, width=height=8, pulse btn[3] for 10 cycles -> at (1,0) with exactly one move_pulse.
REQ-034 btn[2] at (0,0) -> bump for one cycle; coordinates stay (0,0).
REQ-035 Bit 64 (cell (0,1)) =0, btn[1] at (0,0) -> bump; coordinates unchanged.
REQ-036 btn[0] and btn[3] rising the same cycle with both targets open -> only the up move is taken; no further move_pulse follows.
REQ-037 Width=height=2, path open, moves right then down -> at_goal=1 at (1,1) and further buttons are ignored; restart=1 -> (0,0), at_goal=0.
REQ-038 btn glitch of 3 cycles with DEBOUNCE_CYCLES=4 -> no request; reset=0 asserted in CHECK -> outputs zero immediately.
